// File: rtl/fp8_result_packer.sv
// Normalize-and-pack stage for the fp8 add/sub datapath.
// Shifts the raw significand one step per cycle, then emits {sign, exp, frac}.
module fp8_result_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sign,
    input  logic [3:0] in_exp,
    input  logic [4:0] in_sig,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t     state;
    logic       sign_q;
    logic [3:0] exp_q;
    logic [4:0] sig_q;

    logic       norm_done;
    logic [7:0] norm_data;

    // Resolve one NORM step; norm_done=0 means another left shift is needed.
    always_comb begin
        norm_done = 1'b1;
        norm_data = 8'h00;
        if (sig_q == 5'd0 || exp_q == 4'd0) begin
            norm_data = 8'h00;
        end else if (sig_q[4] && exp_q == 4'hF) begin
            norm_data = {sign_q, 4'hF, 3'b111};
        end else if (sig_q[4]) begin
            norm_data = {sign_q, exp_q + 4'd1, sig_q[3:1]};
        end else if (sig_q[3]) begin
            norm_data = {sign_q, exp_q, sig_q[2:0]};
        end else if (exp_q <= 4'd1) begin
            norm_data = 8'h00;
        end else begin
            norm_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            sign_q    <= 1'b0;
            exp_q     <= 4'd0;
            sig_q     <= 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q   <= in_sign;
                        exp_q    <= in_exp;
                        sig_q    <= in_sig;
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (norm_done) begin
                        out_data  <= norm_data;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sig_q <= {sig_q[3:0], 1'b0};
                        exp_q <= exp_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
